// File: rtl/data_memory_byte.sv
// rtl/data_memory_byte.sv - byte-addressable data memory with zeroing init sweep; debug port under DATA_MEMORY_DEBUG_EN
module data_memory_byte #(
  parameter int BITS_SIZE      = 32,
  parameter int SIZE_MEM_DATA  = 16,
  parameter int BITS_EXTENSION = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_step,
  input  logic [BITS_SIZE-1:0]      i_alu_address,
  input  logic [BITS_SIZE-1:0]      i_data_register,
  input  logic                      i_flag_mem_read,
  input  logic                      i_flag_mem_write,
  input  logic [BITS_EXTENSION-1:0] i_ctl_select,
  input  logic                      i_ctl_unsigned,
  input  logic [BITS_SIZE-1:0]      i_debug_address,
  output logic [BITS_SIZE-1:0]      o_data_read,
  output logic                      o_data_valid,
  output logic                      o_misaligned,
  output logic                      o_ready,
  output logic [BITS_SIZE-1:0]      o_debug_data
);

  localparam int ADDR_W = $clog2(SIZE_MEM_DATA);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [ADDR_W-1:0]    r_init_cnt;
  logic [BITS_SIZE-1:0] r_mem [SIZE_MEM_DATA];

  logic [ADDR_W-1:0]    w_idx;
  logic                 w_idle;
  logic                 w_misaligned;
  logic                 w_req;
  logic                 w_do_read;
  logic                 w_do_write;
  logic [3:0]           w_be;
  logic [BITS_SIZE-1:0] w_wdata;
  logic [BITS_SIZE-1:0] w_rd_word;
  logic [7:0]           w_rd_byte;
  logic [15:0]          w_rd_half;
  logic                 w_sign;
  logic [BITS_SIZE-1:0] w_load;
  logic                 w_unused;

  // Upper address bits beyond the depth are ignored, so accesses wrap modulo depth.
  assign w_idx      = i_alu_address[ADDR_W+1:2];
  assign w_idle     = (r_state == ST_IDLE);
  assign w_req      = w_idle & i_step & (i_flag_mem_read | i_flag_mem_write);
  assign w_do_read  = w_idle & i_step & i_flag_mem_read;
  assign w_do_write = w_req & i_flag_mem_write & ~w_misaligned;
  assign o_ready    = w_idle;

  // Alignment rules per access size; the reserved size is always rejected.
  always_comb begin
    w_misaligned = 1'b0;
    case (i_ctl_select)
      2'b00:   w_misaligned = (i_alu_address[1:0] != 2'b00);
      2'b01:   w_misaligned = 1'b0;
      2'b10:   w_misaligned = i_alu_address[0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_data_register;
    case (i_ctl_select)
      2'b00: w_be = 4'b1111;
      2'b01: begin
        w_be    = 4'b0001 << i_alu_address[1:0];
        w_wdata = {4{i_data_register[7:0]}};
      end
      2'b10: begin
        w_be    = i_alu_address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_data_register[15:0]}};
      end
      default: w_be = 4'b0000;
    endcase
    if (!w_do_write) begin
      w_be = 4'b0000;
    end
  end

  // Load path: lane extraction and sign/zero extension from pre-edge contents.
  always_comb begin
    w_rd_word = r_mem[w_idx];
    w_rd_byte = w_rd_word[{i_alu_address[1:0], 3'b000} +: 8];
    w_rd_half = i_alu_address[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    w_sign    = ~i_ctl_unsigned;
    w_load    = w_rd_word;
    case (i_ctl_select)
      2'b01:   w_load = {{24{w_sign & w_rd_byte[7]}}, w_rd_byte};
      2'b10:   w_load = {{16{w_sign & w_rd_half[15]}}, w_rd_half};
      default: w_load = w_rd_word;
    endcase
    if (w_misaligned) begin
      w_load = '0;
    end
  end

  // FSM next state: leave INIT after the last word has been cleared.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: if (r_init_cnt == ADDR_W'(SIZE_MEM_DATA - 1)) w_next_state = ST_IDLE;
      ST_IDLE: w_next_state = ST_IDLE;
      default: w_next_state = ST_INIT;
    endcase
  end

  // FSM state and init sweep counter; any reset restarts the sweep at word 0.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // Storage: INIT clears one word per cycle, IDLE applies lane-masked stores.
  always_ff @(posedge i_clk) begin
    if (!w_idle) begin
      r_mem[r_init_cnt] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered load result, valid strobe and misalignment pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data_read  <= '0;
      o_data_valid <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      o_data_valid <= w_do_read;
      o_misaligned <= w_req & w_misaligned;
      if (w_do_read) begin
        o_data_read <= w_load;
      end
    end
  end

`ifdef DATA_MEMORY_DEBUG_EN
  // Debug snoop of any word, independent of step and FSM state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_debug_data <= '0;
    end else begin
      o_debug_data <= r_mem[i_debug_address[ADDR_W-1:0]];
    end
  end

  assign w_unused = ^{i_alu_address[BITS_SIZE-1:ADDR_W+2], i_debug_address[BITS_SIZE-1:ADDR_W]};
`else
  assign o_debug_data = '0;
  assign w_unused     = ^{i_alu_address[BITS_SIZE-1:ADDR_W+2], i_debug_address};
`endif

endmodule

// File: tb/tb_data_memory_byte.sv
// tb/tb_data_memory_byte.sv - randomized self-checking bench for data_memory_byte against an array model
module tb_data_memory_byte;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_step;
  logic [31:0] i_alu_address;
  logic [31:0] i_data_register;
  logic        i_flag_mem_read;
  logic        i_flag_mem_write;
  logic [1:0]  i_ctl_select;
  logic        i_ctl_unsigned;
  logic [31:0] i_debug_address;
  logic [31:0] o_data_read;
  logic        o_data_valid;
  logic        o_misaligned;
  logic        o_ready;
  logic [31:0] o_debug_data;

  logic [31:0] mem_m [16];
  logic [31:0] last_m;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 i_clk = ~i_clk;

  data_memory_byte #(.BITS_SIZE(32), .SIZE_MEM_DATA(16), .BITS_EXTENSION(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step),
    .i_alu_address(i_alu_address), .i_data_register(i_data_register),
    .i_flag_mem_read(i_flag_mem_read), .i_flag_mem_write(i_flag_mem_write),
    .i_ctl_select(i_ctl_select), .i_ctl_unsigned(i_ctl_unsigned),
    .i_debug_address(i_debug_address), .o_data_read(o_data_read),
    .o_data_valid(o_data_valid), .o_misaligned(o_misaligned),
    .o_ready(o_ready), .o_debug_data(o_debug_data)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check_val({tag, "_read"},  o_data_read, 32'h0);
    check_val({tag, "_valid"}, {31'h0, o_data_valid}, 32'h0);
    check_val({tag, "_mis"},   {31'h0, o_misaligned}, 32'h0);
    check_val({tag, "_ready"}, {31'h0, o_ready}, 32'h0);
    check_val({tag, "_dbg"},   o_debug_data, 32'h0);
  endtask

  task automatic clear_mem_model();
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
  endtask

  // One IDLE-state access: model predicts, DUT is checked just after the edge.
  task automatic access(input logic step, input logic rd, input logic wr, input logic [1:0] sel,
                        input logic uns, input logic [31:0] addr, input logic [31:0] data);
    logic        mis;
    int          idx;
    int          sh;
    logic [31:0] w, rv, b, h, dbg, exp_dbg;
    logic        exp_valid, exp_mis;
    @(negedge i_clk);
    dbg = $urandom;
    i_step = step; i_flag_mem_read = rd; i_flag_mem_write = wr; i_ctl_select = sel;
    i_ctl_unsigned = uns; i_alu_address = addr; i_data_register = data; i_debug_address = dbg;
    mis = (sel == 2'd3) || (sel == 2'd2 && (addr % 2) != 0) || (sel == 2'd0 && (addr % 4) != 0);
    idx = int'((addr / 4) % 16);
    w = mem_m[idx];
`ifdef DATA_MEMORY_DEBUG_EN
    exp_dbg = mem_m[dbg % 16];
`else
    exp_dbg = 32'h0;
`endif
    exp_valid = step && rd;
    exp_mis   = step && (rd || wr) && mis;
    if (exp_valid) begin
      if (mis) rv = 32'h0;
      else if (sel == 2'd1) begin
        b  = (w >> (8 * (addr % 4))) & 32'hFF;
        rv = (!uns && b >= 128) ? b + 32'hFFFFFF00 : b;
      end else if (sel == 2'd2) begin
        h  = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        rv = (!uns && h >= 32768) ? h + 32'hFFFF0000 : h;
      end else rv = w;
      last_m = rv;
    end
    if (step && wr && !mis) begin
      if (sel == 2'd0) mem_m[idx] = data;
      else if (sel == 2'd1) begin
        sh = 8 * int'(addr % 4);
        mem_m[idx] = (w & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
      end else begin
        sh = 16 * int'((addr / 2) % 2);
        mem_m[idx] = (w & ~(32'hFFFF << sh)) | ((data & 32'hFFFF) << sh);
      end
    end
    @(posedge i_clk);
    #1;
    check_val("valid", {31'h0, o_data_valid}, {31'h0, exp_valid});
    check_val("misaligned", {31'h0, o_misaligned}, {31'h0, exp_mis});
    check_val("data_read", o_data_read, last_m);
    check_val("debug", o_debug_data, exp_dbg);
  endtask

  // Requests are held active during the sweep; they must have no effect.
  task automatic init_sweep(input string tag);
    int cyc;
    cyc = 0;
    i_step = 1'b1; i_flag_mem_read = 1'b1; i_flag_mem_write = 1'b1; i_ctl_select = 2'd0;
    i_alu_address = 32'h0; i_data_register = 32'hDEADBEEF;
    i_reset = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge i_clk);
      #1;
      check_val({tag, "_init_valid"}, {31'h0, o_data_valid}, 32'h0);
      check_val({tag, "_init_mis"}, {31'h0, o_misaligned}, 32'h0);
      if (o_ready) begin
        cyc = i;
        break;
      end
    end
    check_val(tag, cyc, 16);
    clear_mem_model();
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) access(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'(i * 4), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    i_reset = 1'b0; i_step = 1'b0; i_alu_address = '0; i_data_register = '0;
    i_flag_mem_read = 1'b0; i_flag_mem_write = 1'b0; i_ctl_select = '0;
    i_ctl_unsigned = 1'b0; i_debug_address = '0;
    last_m = 32'h0;
    clear_mem_model();

    repeat (3) @(posedge i_clk);
    #1;
    chk_zero("rst_hold");
    @(negedge i_clk);
    init_sweep("ready_cycles");
    read_all_zero();

    access(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h4, 32'h8899AABB);
    access(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h5, 32'h00000011);
    access(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h4, 32'h0);
    check_val("sw_sb_lw", o_data_read, 32'h889911BB);

    access(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0000F080);
    access(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0);
    check_val("lb", o_data_read, 32'hFFFFFF80);
    access(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
    check_val("lbu", o_data_read, 32'h00000080);
    access(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    check_val("lh", o_data_read, 32'hFFFFF080);

    access(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h3, 32'hFFFFFFFF);
    access(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    check_val("sh_mis_unchanged", o_data_read, 32'h0000F080);
    access(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h2, 32'h0);
    check_val("lw_mis_data", o_data_read, 32'h0);

    access(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h8, 32'h7);
    access(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h8, 32'h5);
    check_val("rbw_old", o_data_read, 32'h7);
    access(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h8, 32'h0);
    check_val("rbw_new", o_data_read, 32'h5);

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      s = 2'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : 3);
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd0) a[1:0] = 2'b00;
        else if (s == 2'd2) a[0] = 1'b0;
      end
      access($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), s, 1'($urandom), a, $urandom);
    end

    access(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h12345678);
    access(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk_zero("rst_async");
    last_m = 32'h0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (7) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge i_clk);
    init_sweep("ready_after_mid");
    read_all_zero();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
